run_length_packer: RTL and testbench

- Downstream consumer of the serial transition-detector stage.
- Takes the accepted serial bit stream and the detector's per-bit transition flag, and packs each completed run of identical bits into a {bit value, run length} record.
- Records are buffered in a small FIFO and drained over a valid/ready interface to the framing/statistics logic.
- Long runs are split at the counter maximum. FIFO overflow is flagged, never silent.

---
 rtl/run_length_packer.sv | 139 +++++++++++++
 tb/tb_run_length_packer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_packer.sv
// Packs runs of identical serial bits into {bit, length} records and buffers
// them in a small FIFO drained over a valid/ready handshake.
module run_length_packer #(
  parameter int LEN_W = 4,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_vld,
  input  logic             bit_in,
  input  logic             trans_in,
  input  logic             flush,
  output logic             rec_vld,
  input  logic             rec_rdy,
  output logic             rec_bit,
  output logic [LEN_W-1:0] rec_len,
  output logic [PTR_W:0]   level,
  output logic             ovf
);

  localparam logic [LEN_W-1:0] MAX_LEN = '1;
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);
  localparam logic [PTR_W:0]   FULL_LV = (PTR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic               cur_bit_q, cur_bit_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               push;
  logic               push_bit;
  logic [LEN_W-1:0]   push_len;

  logic [LEN_W:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]     level_q, level_d;
  logic               ovf_q;
  logic               full, pop, wr_en;
  logic [LEN_W:0]     head;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cur_bit_d = cur_bit_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    push      = 1'b0;
    push_bit  = cur_bit_q;
    push_len  = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bit_vld) begin
          cur_bit_d = bit_in;
          cnt_d     = ONE;
          state_d   = RUN;
          pend_d    = flush;
        end else begin
          pend_d    = 1'b0;
        end
      end
      RUN: begin
        if (bit_vld) begin
          // A flush arriving alongside a bit waits until a bit-free cycle.
          pend_d = flush | pend_q;
          if (trans_in) begin
            push      = 1'b1;
            cur_bit_d = bit_in;
            cnt_d     = ONE;
          end else if (cnt_q == MAX_LEN) begin
            push  = 1'b1;
            cnt_d = ONE;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end else if (flush | pend_q) begin
          push    = 1'b1;
          state_d = IDLE;
          pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (level_q == FULL_LV);
  assign rec_vld = (level_q != '0);
  assign pop     = rec_vld & rec_rdy;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en   = push & (~full | pop);

  always_comb begin
    level_d = level_q;
    unique case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_bit_q <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_bit_q <= cur_bit_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      level_q   <= level_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push & full & ~pop) ovf_q <= 1'b1;
    end
  end

  // NOTE: storage is left unreset; entries are only observable once written,
  // and the outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {push_bit, push_len};
  end

  assign head    = mem_q[rd_ptr_q];
  assign rec_bit = rec_vld ? head[LEN_W] : 1'b0;
  assign rec_len = rec_vld ? head[LEN_W-1:0] : '0;
  assign level   = level_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_run_length_packer.sv
// Scoreboard bench for run_length_packer: expected records are queued as
// stimulus is driven and compared whenever the DUT hands a record over.
module tb_run_length_packer;

  localparam int LEN_W = 4;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bit_vld, bit_in, trans_in, flush;
  logic             rec_vld, rec_rdy, rec_bit;
  logic [LEN_W-1:0] rec_len;
  logic [PTR_W:0]   level;
  logic             ovf;

  int errors = 0;
  int checks = 0;
  logic prev_bit = 1'b0;
  logic [LEN_W:0] exp_q[$];

  run_length_packer #(.LEN_W(LEN_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .rst_n(rst_n), .bit_vld(bit_vld), .bit_in(bit_in),
    .trans_in(trans_in), .flush(flush), .rec_vld(rec_vld), .rec_rdy(rec_rdy),
    .rec_bit(rec_bit), .rec_len(rec_len), .level(level), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Compare each record as it is accepted (pop happens on the next rising edge).
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rec_vld === 1'b1 && rec_rdy === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rec_unexpected: got bit=%0b len=%0d, none expected", rec_bit, rec_len);
      end else begin
        logic [LEN_W:0] e;
        e = exp_q.pop_front();
        if ({rec_bit, rec_len} !== e) begin
          errors++;
          $display("FAIL rec_data: got bit=%0b len=%0d, expected bit=%0b len=%0d",
                   rec_bit, rec_len, e[LEN_W], e[LEN_W-1:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b, input logic f);
    bit_vld  = 1'b1;
    bit_in   = b;
    trans_in = (b != prev_bit);
    flush    = f;
    prev_bit = b;
    step();
    bit_vld  = 1'b0;
    trans_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic expect_rec(input logic b, input int l);
    exp_q.push_back({b, LEN_W'(l)});
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    prev_bit = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    rec_rdy = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && rec_vld === 1'b0) done = 1'b1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d records never seen, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (level !== '0) begin
      errors++;
      $display("FAIL %s_level: got %0d, expected 0", name, level);
    end
    checks++;
    if ({rec_vld, rec_bit, rec_len} !== '0) begin
      errors++;
      $display("FAIL %s_empty_out: got vld=%0b bit=%0b len=%0d, expected all 0",
               name, rec_vld, rec_bit, rec_len);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bit_vld = 1'b0; bit_in = 1'b0; trans_in = 1'b0;
    flush = 1'b0; rec_rdy = 1'b0;
    #3;
    checks++;
    if ({rec_vld, rec_bit, rec_len, level, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got vld=%0b bit=%0b len=%0d level=%0d ovf=%0b, expected all 0",
               rec_vld, rec_bit, rec_len, level, ovf);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checks++;
    if ({rec_vld, level, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_idle: got vld=%0b level=%0d ovf=%0b, expected 0",
               rec_vld, level, ovf);
    end
  endtask

  task automatic test_basic();
    rec_rdy = 1'b1;
    expect_rec(1'b0, 3);
    expect_rec(1'b1, 2);
    send(0, 0); send(0, 0); send(0, 0); send(1, 0); send(1, 0);
    do_flush();
    drain("basic");
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL basic_ovf: got %0b, expected 0", ovf);
    end
  endtask

  task automatic test_split();
    rec_rdy = 1'b1;
    expect_rec(1'b1, 15);
    expect_rec(1'b1, 5);
    for (int i = 0; i < 20; i++) send(1, 0);
    do_flush();
    drain("split");
  endtask

  task automatic test_overflow();
    rec_rdy = 1'b0;
    expect_rec(1'b1, 2);
    expect_rec(1'b0, 2);
    expect_rec(1'b1, 2);
    expect_rec(1'b0, 2);
    for (int r = 0; r < 5; r++) begin
      send(~r[0], 0);
      send(~r[0], 0);
    end
    do_flush();
    @(negedge clk);
    checks++;
    if (level !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL ovf_level: got %0d, expected %0d", level, DEPTH);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: got %0b, expected 1", ovf);
    end
    drain("ovf_drain");
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %0b, expected 1", ovf);
    end
  endtask

  task automatic test_full_pop_push();
    apply_reset();
    rec_rdy = 1'b0;
    expect_rec(1'b1, 2);
    expect_rec(1'b0, 2);
    expect_rec(1'b1, 2);
    expect_rec(1'b0, 2);
    send(1, 0); send(1, 0); send(0, 0); send(0, 0); send(1, 0);
    send(1, 0); send(0, 0); send(0, 0); send(1, 0);
    @(negedge clk);
    checks++;
    if (level !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL full_fill_level: got %0d, expected %0d", level, DEPTH);
    end
    rec_rdy = 1'b1;
    expect_rec(1'b1, 1);
    send(0, 0);
    rec_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 3'(DEPTH)) begin
      errors++;
      $display("FAIL full_pushpop_level: got %0d, expected %0d", level, DEPTH);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop_ovf: got %0b, expected 0", ovf);
    end
    rec_rdy = 1'b1;
    expect_rec(1'b0, 1);
    do_flush();
    drain("full_pushpop");
  endtask

  task automatic test_mid_reset();
    rec_rdy = 1'b1;
    for (int i = 0; i < 6; i++) send(0, 0);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({rec_vld, level, ovf} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got vld=%0b level=%0d ovf=%0b, expected 0",
               rec_vld, level, ovf);
    end
    step();
    rst_n = 1'b1;
    prev_bit = 1'b0;
    expect_rec(1'b1, 2);
    send(1, 0); send(1, 0);
    do_flush();
    drain("midreset");
  endtask

  task automatic test_pending_flush();
    rec_rdy = 1'b0;
    expect_rec(1'b0, 3);
    send(0, 0); send(0, 0); send(0, 1);
    @(negedge clk);
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL pend_early: got level %0d, expected 0", level);
    end
    step();
    @(negedge clk);
    checks++;
    if (level !== 3'd1) begin
      errors++;
      $display("FAIL pend_push: got level %0d, expected 1", level);
    end
    do_flush();
    @(negedge clk);
    checks++;
    if (level !== 3'd1) begin
      errors++;
      $display("FAIL idle_flush: got level %0d, expected 1", level);
    end
    expect_rec(1'b1, 1);
    send(1, 0);
    do_flush();
    drain("pend");
  endtask

  task automatic test_back_to_back();
    rec_rdy = 1'b0;
    expect_rec(1'b1, 3);
    send(1, 1); send(1, 0); send(1, 0);
    @(negedge clk);
    checks++;
    if (level !== 3'd0) begin
      errors++;
      $display("FAIL b2b_held: got level %0d, expected 0", level);
    end
    step();
    @(negedge clk);
    checks++;
    if (level !== 3'd1) begin
      errors++;
      $display("FAIL b2b_push: got level %0d, expected 1", level);
    end
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_overflow();
    test_full_pop_push();
    test_mid_reset();
    test_pending_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
